// File: rtl/chess_input_ctrl_if.sv
// Board-side bundle for the chess input stage: raw keys and
// lever in, cursor, command pulses and displays out.
interface chess_input_ctrl_if;
    logic       key_row_n;
    logic       key_col_n;
    logic       key_select_n;
    logic       key_place_n;
    logic       up;
    logic [2:0] row;
    logic [2:0] col;
    logic       select_pulse;
    logic       place_pulse;
    logic [2:0] src_row;
    logic [2:0] src_col;
    logic       holding;
    logic [6:0] row_seg;
    logic [6:0] col_seg;

    modport master (
        output key_row_n, key_col_n, key_select_n, key_place_n, up,
        input  row, col, select_pulse, place_pulse,
        input  src_row, src_col, holding, row_seg, col_seg
    );

    modport slave (
        input  key_row_n, key_col_n, key_select_n, key_place_n, up,
        output row, col, select_pulse, place_pulse,
        output src_row, src_col, holding, row_seg, col_seg
    );
endinterface

// File: rtl/chess_input_ctrl.sv
// Chess board input stage: key sync/debounce, wrapping cursor,
// select/place phase tracking and hex cursor displays.
module chess_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               reset,
    chess_input_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, HELD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // bit order: row, col, select, place, lever
    logic [4:0] raw;
    logic [4:0] sync1;
    logic [4:0] sync2;

    logic [3:0]       key_k;
    logic [3:0]       key_kd;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];

    logic       up_s;
    logic       sel_go;
    logic       place_go;
    state_t     state;

    logic [2:0] row_q;
    logic [2:0] col_q;
    logic       row_pend;
    logic       row_pdir;
    logic       col_pend;
    logic       col_pdir;
    logic [2:0] src_row_q;
    logic [2:0] src_col_q;
    logic       holding_q;
    logic       sel_pulse_q;
    logic       plc_pulse_q;

    function automatic logic [2:0] step(input logic [2:0] v,
                                        input logic inc);
        return inc ? v + 3'd1 : v - 3'd1;
    endfunction

    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] s;
        unique case (v)
            3'd0: s = 7'b1000000;
            3'd1: s = 7'b1111001;
            3'd2: s = 7'b0100100;
            3'd3: s = 7'b0110000;
            3'd4: s = 7'b0011001;
            3'd5: s = 7'b0010010;
            3'd6: s = 7'b0000010;
            3'd7: s = 7'b1111000;
        endcase
        return s;
    endfunction

    assign raw = {bus.up, bus.key_place_n, bus.key_select_n,
                  bus.key_col_n, bus.key_row_n};

    // two-flop synchronizers, idle-high like released keys
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // per-key debounce: accept a change after a full run of agreement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_k  <= '1;
            key_kd <= '1;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            key_kd <= key_k;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == key_k[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    key_k[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press    = key_kd & ~key_k;
    assign up_s     = sync2[4];
    assign place_go = (state == HELD) & press[3];
    assign sel_go   = press[2] & ~place_go;

    // cursor moves; deferred one cycle when a place is being issued
    // so the place pulse sees the pre-move destination
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q    <= '0;
            col_q    <= '0;
            row_pend <= 1'b0;
            row_pdir <= 1'b0;
            col_pend <= 1'b0;
            col_pdir <= 1'b0;
        end else if (place_go) begin
            row_pend <= press[0];
            row_pdir <= up_s;
            col_pend <= press[1];
            col_pdir <= up_s;
        end else begin
            row_pend <= 1'b0;
            col_pend <= 1'b0;
            if (press[0]) row_q <= step(row_q, up_s);
            else if (row_pend) row_q <= step(row_q, row_pdir);
            if (press[1]) col_q <= step(col_q, up_s);
            else if (col_pend) col_q <= step(col_q, col_pdir);
        end
    end

    // select/place phase FSM with registered command pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            holding_q   <= 1'b0;
            src_row_q   <= '0;
            src_col_q   <= '0;
            sel_pulse_q <= 1'b0;
            plc_pulse_q <= 1'b0;
        end else begin
            sel_pulse_q <= sel_go;
            plc_pulse_q <= place_go;
            if (sel_go) begin
                src_row_q <= row_q;
                src_col_q <= col_q;
                holding_q <= 1'b1;
                state     <= HELD;
            end else if (place_go) begin
                holding_q <= 1'b0;
                state     <= IDLE;
            end
        end
    end

    assign bus.row          = row_q;
    assign bus.col          = col_q;
    assign bus.src_row      = src_row_q;
    assign bus.src_col      = src_col_q;
    assign bus.holding      = holding_q;
    assign bus.select_pulse = sel_pulse_q;
    assign bus.place_pulse  = plc_pulse_q;
    assign bus.row_seg      = seg7(row_q);
    assign bus.col_seg      = seg7(col_q);
endmodule

// File: tb/tb_chess_input_ctrl.sv
// Randomized scoreboard bench for chess_input_ctrl: a key-level
// model predicts every command pulse and the resting cursor state.
module tb_chess_input_ctrl;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    chess_input_ctrl_if bus ();

    chess_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic       sel;
        logic       plc;
        logic [2:0] r;
        logic [2:0] c;
        logic [2:0] sr;
        logic [2:0] sc;
        logic       hold;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    int m_row = 0;
    int m_col = 0;
    int m_sr  = 0;
    int m_sc  = 0;
    bit m_hold = 1'b0;

    logic [6:0] seg_tab [8] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
    };

    task automatic check(input string name, input int act,
                         input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every pulse cycle must match the next prediction
    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        if (reset && (bus.select_pulse || bus.place_pulse)) begin
            a.sel  = bus.select_pulse;
            a.plc  = bus.place_pulse;
            a.r    = bus.row;
            a.c    = bus.col;
            a.sr   = bus.src_row;
            a.sc   = bus.src_col;
            a.hold = bus.holding;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got %0h expected none at %0t",
                         a, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse", int'(a), int'(e));
            end
        end
    end

    function automatic int wrap(input int v, input bit move,
                                input bit inc);
        if (!move) return v;
        return inc ? (v + 1) % 8 : (v + 7) % 8;
    endfunction

    // key-level reference: one debounced press of the keys in m
    task automatic model(input logic [3:0] m, input bit dir);
        ev_t e;
        int  nr;
        int  nc;
        nr = wrap(m_row, m[0], dir);
        nc = wrap(m_col, m[1], dir);
        if (m_hold && m[3]) begin
            e.sel  = 1'b0;
            e.plc  = 1'b1;
            e.r    = 3'(m_row);
            e.c    = 3'(m_col);
            e.sr   = 3'(m_sr);
            e.sc   = 3'(m_sc);
            e.hold = 1'b0;
            exp_q.push_back(e);
            m_hold = 1'b0;
        end else if (m[2]) begin
            m_sr   = m_row;
            m_sc   = m_col;
            m_hold = 1'b1;
            e.sel  = 1'b1;
            e.plc  = 1'b0;
            e.r    = 3'(nr);
            e.c    = 3'(nc);
            e.sr   = 3'(m_sr);
            e.sc   = 3'(m_sc);
            e.hold = 1'b1;
            exp_q.push_back(e);
        end
        m_row = nr;
        m_col = nc;
    endtask

    task automatic model_reset();
        m_row  = 0;
        m_col  = 0;
        m_sr   = 0;
        m_sc   = 0;
        m_hold = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] low);
        bus.key_row_n    = ~low[0];
        bus.key_col_n    = ~low[1];
        bus.key_select_n = ~low[2];
        bus.key_place_n  = ~low[3];
    endtask

    task automatic press(input logic [3:0] m, input bit dir);
        bus.up = dir;
        model(m, dir);
        set_keys(m);
        cyc($urandom_range(D + 2, D + 8));
        set_keys(4'b0000);
        cyc($urandom_range(D + 4, D + 8));
    endtask

    task automatic glitch(input logic [3:0] m);
        set_keys(m);
        cyc($urandom_range(1, D - 1));
        set_keys(4'b0000);
        cyc(D + 4);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".row"}, bus.row, m_row);
        check({tag, ".col"}, bus.col, m_col);
        check({tag, ".src_row"}, bus.src_row, m_sr);
        check({tag, ".src_col"}, bus.src_col, m_sc);
        check({tag, ".holding"}, bus.holding, m_hold);
        check({tag, ".row_seg"}, bus.row_seg, seg_tab[m_row]);
        check({tag, ".col_seg"}, bus.col_seg, seg_tab[m_col]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".row"}, bus.row, 0);
        check({tag, ".col"}, bus.col, 0);
        check({tag, ".src_row"}, bus.src_row, 0);
        check({tag, ".src_col"}, bus.src_col, 0);
        check({tag, ".holding"}, bus.holding, 0);
        check({tag, ".sel_pulse"}, bus.select_pulse, 0);
        check({tag, ".plc_pulse"}, bus.place_pulse, 0);
        check({tag, ".row_seg"}, bus.row_seg, 7'b1000000);
        check({tag, ".col_seg"}, bus.col_seg, 7'b1000000);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        set_keys(4'b0000);
        bus.up = 1'b1;
        #1;
        reset = 1'b0;
        #3;
        check_reset("reset");
        cyc(2);
        reset = 1'b1;
        cyc(2);

        repeat (4) press(4'b0001, 1'b1);
        check_state("row_up4");
        repeat (4) press(4'b0001, 1'b0);
        press(4'b0001, 1'b0);
        check_state("row_wrap_down");
        press(4'b0001, 1'b1);
        check_state("row_wrap_up");

        model(4'b0100, 1'b1);
        repeat (3) begin
            set_keys(4'b0100);
            cyc(2);
            set_keys(4'b0000);
            cyc(2);
        end
        set_keys(4'b0100);
        cyc(10);
        set_keys(4'b0000);
        cyc(10);
        check_state("bounce_sel");
        press(4'b1000, 1'b1);
        check_state("place0");

        press(4'b1000, 1'b1);
        check_state("idle_place");
        repeat (2) press(4'b0001, 1'b1);
        repeat (3) press(4'b0010, 1'b0);
        press(4'b0100, 1'b1);
        check_state("sel_2_5");
        press(4'b0001, 1'b1);
        press(4'b1000, 1'b1);
        check_state("place_3_5");

        press(4'b0100, 1'b1);
        press(4'b1100, 1'b1);
        check_state("held_both");
        press(4'b1100, 1'b1);
        check_state("idle_both");

        press(4'b1011, 1'b1);
        check_state("place_move");
        press(4'b0111, 1'b0);
        check_state("sel_move");

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0)
                glitch(4'($urandom_range(1, 15)));
            press(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
            check_state("rand");
        end

        while (m_row != 6) press(4'b0001, 1'b1);
        while (m_col != 1) press(4'b0010, 1'b1);
        press(4'b0100, 1'b1);
        check_state("held_6_1");
        pulse_reset();
        cyc(20);
        check_state("after_reset");

        set_keys(4'b0100);
        cyc(2);
        pulse_reset();
        model(4'b0100, 1'b1);
        cyc(12);
        set_keys(4'b0000);
        cyc(10);
        check_state("held_through_reset");

        cyc(10);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
